if_id_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS pipeline: owns the program counter and the
//  IF/ID pipeline register. Consumes PCwrite/if_id_write from the load-use hazard unit and

---
 rtl/if_id_stage.sv | 111 +++++++++++
 tb/tb_if_id_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// ============================================================================
//  Module  : if_id_stage
//  Purpose : MIPS instruction-fetch stage: program counter, IF/ID pipeline
//            register and saturating stall/flush performance counters.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PCwrite,
  input  logic             if_id_write,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic [4:0]       if_id_rs,
  output logic [4:0]       if_id_rt,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;
  logic [31:0]        pc_plus4;

  // Natural 32-bit wrap; low two bits of pc pass through unchanged.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = RUN;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    stall_d = stall_q;
    flush_d = flush_q;

    if (state_q == RUN) begin
      if (redirect) begin
        // A flush overrides any stall request from the hazard unit.
        pc_d    = redirect_pc;
        instr_d = NOP_INSTR;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
        if (flush_q != {CNT_W{1'b1}}) flush_d = flush_q + CNT_W'(1);
      end else begin
        if (PCwrite) begin
          pc_d = pc_plus4;
        end else if (stall_q != {CNT_W{1'b1}}) begin
          stall_d = stall_q + CNT_W'(1);
        end
        if (if_id_write) begin
          instr_d = imem_instr;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_rs    = instr_q[25:21];
  assign if_id_rt    = instr_q[20:16];
  assign if_id_valid = valid_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage; small counter width keeps saturation runs short.
`default_nettype none

module tb_if_id_stage;

  localparam int CW = 4;
  localparam logic [CW-1:0] SAT = {CW{1'b1}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          PCwrite, if_id_write, redirect;
  logic [31:0]   redirect_pc, imem_instr;
  logic [31:0]   pc, if_id_instr, if_id_pc4;
  logic [4:0]    if_id_rs, if_id_rt;
  logic          if_id_valid;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic          fixed_mode;
  logic [31:0]   exp_i;

  int checks = 0;
  int errors = 0;

  if_id_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h0), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .PCwrite(PCwrite), .if_id_write(if_id_write),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_instr(imem_instr),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_valid(if_id_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory model: fixed word, or an address-derived word.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {8'h8C, a[23:0]};
  endfunction

  always_comb imem_instr = fixed_mode ? 32'h2001_0005 : imem(pc);

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic pw, input logic iw, input logic rd, input logic [31:0] rpc);
    PCwrite = pw; if_id_write = iw; redirect = rd; redirect_pc = rpc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fixed_mode = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step(); step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h exp %h", pc, 32'h0); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h exp %h", if_id_instr, 32'h0); end
    checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h exp %h", if_id_pc4, 32'h0); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", if_id_valid); end
    checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL rst_cnt: got %h/%h exp 0/0", stall_cnt, flush_cnt); end
    rst_n = 1'b1;
    step();
    checks++; if (pc !== 32'h0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL boot_hold: got pc %h valid %b exp 0 0", pc, if_id_valid); end
    step();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL run1_pc: got %h exp %h", pc, 32'h4); end
    checks++; if (if_id_instr !== 32'h2001_0005 || if_id_valid !== 1'b1) begin errors++; $display("FAIL run1_instr: got %h v%b exp 20010005 v1", if_id_instr, if_id_valid); end
    checks++; if (if_id_pc4 !== 32'h4) begin errors++; $display("FAIL run1_pc4: got %h exp %h", if_id_pc4, 32'h4); end
    checks++; if (if_id_rs !== 5'd0 || if_id_rt !== 5'd1) begin errors++; $display("FAIL run1_rsrt: got %0d/%0d exp 0/1", if_id_rs, if_id_rt); end
    step();
    checks++; if (pc !== 32'h8 || if_id_pc4 !== 32'h8) begin errors++; $display("FAIL run2: got pc %h pc4 %h exp 8 8", pc, if_id_pc4); end
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL stall_pc: got %h exp %h", pc, 32'h8); end
    checks++; if (if_id_instr !== 32'h2001_0005 || if_id_pc4 !== 32'h8 || if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_ifid: got %h %h v%b exp 20010005 8 v1", if_id_instr, if_id_pc4, if_id_valid); end
    checks++; if (stall_cnt !== CW'(1)) begin errors++; $display("FAIL stall_cnt1: got %0d exp 1", stall_cnt); end
    fixed_mode = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    exp_i = imem(32'h8);
    checks++; if (pc !== 32'hC || if_id_instr !== exp_i || if_id_pc4 !== 32'hC) begin errors++; $display("FAIL stall_resume: got pc %h instr %h pc4 %h exp c %h c", pc, if_id_instr, if_id_pc4, exp_i); end
  endtask

  task automatic test_independent();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    exp_i = imem(32'hC);
    checks++; if (pc !== 32'hC || if_id_instr !== exp_i || if_id_pc4 !== 32'h10) begin errors++; $display("FAIL refetch: got pc %h instr %h pc4 %h exp c %h 10", pc, if_id_instr, if_id_pc4, exp_i); end
    checks++; if (stall_cnt !== CW'(2)) begin errors++; $display("FAIL refetch_stall: got %0d exp 2", stall_cnt); end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checks++; if (pc !== 32'h10 || if_id_instr !== exp_i || if_id_pc4 !== 32'h10) begin errors++; $display("FAIL drop: got pc %h instr %h pc4 %h exp 10 %h 10", pc, if_id_instr, if_id_pc4, exp_i); end
    checks++; if (stall_cnt !== CW'(2)) begin errors++; $display("FAIL drop_stall: got %0d exp 2", stall_cnt); end
  endtask

  task automatic test_redirect();
    drive(1'b0, 1'b0, 1'b1, 32'h40);
    step();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL redir_pc: got %h exp %h", pc, 32'h40); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) begin errors++; $display("FAIL redir_bubble: got v%b %h %h exp v0 0 0", if_id_valid, if_id_instr, if_id_pc4); end
    checks++; if (flush_cnt !== CW'(1) || stall_cnt !== CW'(2)) begin errors++; $display("FAIL redir_cnt: got %0d/%0d exp 1/2", flush_cnt, stall_cnt); end
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    exp_i = imem(32'h40);
    checks++; if (pc !== 32'h44 || if_id_instr !== exp_i || if_id_pc4 !== 32'h44 || if_id_valid !== 1'b1) begin errors++; $display("FAIL redir_next: got pc %h instr %h pc4 %h v%b exp 44 %h 44 v1", pc, if_id_instr, if_id_pc4, if_id_valid, exp_i); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    exp_i = imem(32'hFFFF_FFFC);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h exp %h", pc, 32'h0); end
    checks++; if (if_id_instr !== exp_i || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1) begin errors++; $display("FAIL wrap_ifid: got %h %h v%b exp %h 0 v1", if_id_instr, if_id_pc4, if_id_valid, exp_i); end
    drive(1'b1, 1'b1, 1'b1, 32'h103);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    checks++; if (pc !== 32'h107 || if_id_pc4 !== 32'h107) begin errors++; $display("FAIL unaligned: got pc %h pc4 %h exp 107 107", pc, if_id_pc4); end
    checks++; if (flush_cnt !== CW'(3)) begin errors++; $display("FAIL flush3: got %0d exp 3", flush_cnt); end
  endtask

  task automatic test_saturate();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < (1 << CW) + 3; i++) step();
    checks++; if (stall_cnt !== SAT) begin errors++; $display("FAIL stall_sat: got %0d exp %0d", stall_cnt, SAT); end
    drive(1'b1, 1'b1, 1'b1, 32'h200);
    for (int i = 0; i < (1 << CW); i++) step();
    checks++; if (flush_cnt !== SAT) begin errors++; $display("FAIL flush_sat: got %0d exp %0d", flush_cnt, SAT); end
    checks++; if (stall_cnt !== SAT) begin errors++; $display("FAIL stall_keep: got %0d exp %0d", stall_cnt, SAT); end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 1'b1, 32'h300);
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0 || if_id_instr !== 32'h0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL async_rst: got pc %h instr %h v%b exp 0 0 v0", pc, if_id_instr, if_id_valid); end
    checks++; if (stall_cnt !== '0 || flush_cnt !== '0 || if_id_pc4 !== 32'h0) begin errors++; $display("FAIL async_rst_cnt: got %0d/%0d pc4 %h exp 0/0 0", stall_cnt, flush_cnt, if_id_pc4); end
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 32'h80);
    step();
    checks++; if (pc !== 32'h0 || flush_cnt !== '0 || stall_cnt !== '0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL boot_ignore: got pc %h f%0d s%0d v%b exp 0 0 0 v0", pc, flush_cnt, stall_cnt, if_id_valid); end
    step();
    checks++; if (pc !== 32'h80 || flush_cnt !== CW'(1)) begin errors++; $display("FAIL post_boot_redir: got pc %h f%0d exp 80 1", pc, flush_cnt); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_independent();
    test_redirect();
    test_wrap();
    test_saturate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
